// File: rtl/deserializer.sv
// MSB-first serial-to-parallel deserializer with a bit-count field and a one-cycle valid pulse.
// Optional macro DESERIALIZER_LSB_ALIGN_EN right-aligns partial words instead of left-aligning them.
module deserializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int DATA_MOD_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      ser_data_i,
    input  logic                      ser_data_val_i,
    output logic [DATA_BUS_WIDTH-1:0] deser_data_o,
    output logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o
);

    localparam int CW = $clog2(DATA_BUS_WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MIN  = CW'(3);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_BUS_WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_BUS_WIDTH);

    typedef enum logic {
        IDLE_S = 1'b0,
        RECV_S = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [DATA_BUS_WIDTH-1:0]   buf_q, buf_d;
    logic [DATA_BUS_WIDTH-1:0]   data_q, data_d;
    logic [DATA_MOD_WIDTH-1:0]   mod_q, mod_d;
    logic                        val_q, val_d;

    // The buffer is cleared at each word start, so its unused upper bits are always zero.
    function automatic logic [DATA_BUS_WIDTH-1:0] align_partial(
        input logic [DATA_BUS_WIDTH-1:0] bits,
        input logic [CW-1:0]             k
    );
`ifdef DESERIALIZER_LSB_ALIGN_EN
        align_partial = bits;
`else
        align_partial = bits << (CNT_FULL - k);
`endif
    endfunction

    // State, counter, shift buffer and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE_S;
            cnt_q   <= {CW{1'b0}};
            buf_q   <= {DATA_BUS_WIDTH{1'b0}};
            data_q  <= {DATA_BUS_WIDTH{1'b0}};
            mod_q   <= {DATA_MOD_WIDTH{1'b0}};
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
        end
    end

    // Next-state logic: bit capture, word completion and burst termination.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
        case (state_q)
            IDLE_S: begin
                if (ser_data_val_i) begin
                    state_d = RECV_S;
                    cnt_d   = CNT_ONE;
                    buf_d   = {{(DATA_BUS_WIDTH-1){1'b0}}, ser_data_i};
                end else begin
                    cnt_d = {CW{1'b0}};
                    buf_d = {DATA_BUS_WIDTH{1'b0}};
                end
            end
            RECV_S: begin
                if (ser_data_val_i) begin
                    if (cnt_q == CNT_LAST) begin
                        data_d = {buf_q[DATA_BUS_WIDTH-2:0], ser_data_i};
                        mod_d  = {DATA_MOD_WIDTH{1'b0}};
                        val_d  = 1'b1;
                        cnt_d  = {CW{1'b0}};
                        buf_d  = {DATA_BUS_WIDTH{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                        buf_d = {buf_q[DATA_BUS_WIDTH-2:0], ser_data_i};
                    end
                end else begin
                    state_d = IDLE_S;
                    cnt_d   = {CW{1'b0}};
                    buf_d   = {DATA_BUS_WIDTH{1'b0}};
                    // Runt bursts of one or two bits leave the outputs untouched.
                    if (cnt_q >= CNT_MIN) begin
                        data_d = align_partial(buf_q, cnt_q);
                        mod_d  = cnt_q[DATA_MOD_WIDTH-1:0];
                        val_d  = 1'b1;
                    end else begin
                        val_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE_S;
                cnt_d   = {CW{1'b0}};
                buf_d   = {DATA_BUS_WIDTH{1'b0}};
            end
        endcase
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer, checked against a queue-based burst model.
module tb_deserializer;

    localparam int W  = 16;
    localparam int MW = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          ser_data_i;
    logic          ser_data_val_i;
    logic [W-1:0]  deser_data_o;
    logic [MW-1:0] deser_data_mod_o;
    logic          deser_data_val_o;

    int n_vec = 0;
    int n_err = 0;

    bit            cur[$];
    logic [W-1:0]  exp_data;
    logic [MW-1:0] exp_mod;
    logic          exp_val;

    deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(MW)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .ser_data_i       (ser_data_i),
        .ser_data_val_i   (ser_data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Place the k received bits in a word, first bit most significant among them.
    function automatic logic [W-1:0] pack_bits(input int k, input bit first_full);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < k; i++) begin
`ifdef DESERIALIZER_LSB_ALIGN_EN
            w[k-1-i] = cur[i];
`else
            w[W-1-i] = cur[i];
`endif
        end
        if (first_full) w = w; // full word: both alignments coincide since k == W
        return w;
    endfunction

    task automatic model_apply(input logic v, input logic b);
        exp_val = 1'b0;
        if (v) begin
            cur.push_back(b);
            if (cur.size() == W) begin
                exp_data = pack_bits(W, 1'b1);
                exp_mod  = '0;
                exp_val  = 1'b1;
                cur.delete();
            end
        end else begin
            if (cur.size() >= 3) begin
                exp_data = pack_bits(cur.size(), 1'b0);
                exp_mod  = MW'(cur.size());
                exp_val  = 1'b1;
            end
            cur.delete();
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".val"},  32'(deser_data_val_o), 32'(exp_val));
        chk({tag, ".data"}, 32'(deser_data_o),     32'(exp_data));
        chk({tag, ".mod"},  32'(deser_data_mod_o), 32'(exp_mod));
    endtask

    // One cycle: check outputs from the previous edge, then drive the next input.
    task automatic step(input logic v, input logic b);
        @(negedge clk_i);
        check_outputs("cyc");
        ser_data_val_i = v;
        ser_data_i     = v ? b : 1'($urandom_range(0, 1));
        model_apply(v, b);
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) step(1'b1, w[i]);
    endtask

    task automatic send_bits(input logic [7:0] bits, input int k);
        for (int i = k - 1; i >= 0; i--) step(1'b1, bits[i]);
    endtask

    initial begin
        rst_n_i = 1'b0; ser_data_i = 1'b0; ser_data_val_i = 1'b0;
        exp_data = '0; exp_mod = '0; exp_val = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n_i = 1'b1;
        step(1'b0, 1'b0);

        // Full word, then drop valid: single pulse.
        send_word(16'hA5C3);
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        // Partial word of five bits.
        send_bits(8'b10110, 5);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        // Runts: 2 bits, gap, 1 bit.
        send_bits(8'b11, 2);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        send_bits(8'b1, 1);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        // Back-to-back full words.
        send_word(16'h1234);
        send_word(16'hFEDC);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        // Minimum partial.
        send_bits(8'b101, 3);
        step(1'b0, 1'b0); step(1'b0, 1'b0);

        // Reset mid-burst after nine bits.
        send_bits(8'hFF, 8);
        send_bits(8'h1, 1);
        #2;
        rst_n_i = 1'b0;
        cur.delete();
        exp_data = '0; exp_mod = '0; exp_val = 1'b0;
        #1;
        check_outputs("rst_async");
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n_i = 1'b1;
        send_bits(8'hF, 4);
        step(1'b0, 1'b0); step(1'b0, 1'b0);

        // Random bursts of varied length and gaps.
        for (int n = 0; n < 300; n++) begin
            int len;
            int gap;
            len = $urandom_range(1, 40);
            gap = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)));
            for (int i = 0; i < gap; i++) step(1'b0, 1'b0);
        end
        step(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's MSB-first serializer.
- Samples a 1-bit serial stream qualified by a valid strobe and reassembles it into parallel words.
- Reports how many bits each word carries, then emits the word with a one-cycle valid pulse.
- Sits at the far end of the serial link and feeds parallel consumers.

Parameters:
- DATA_BUS_WIDTH, 16, width of the reassembled parallel word; must be >= 4.
- DATA_MOD_WIDTH, 4, width of the bit-count field; must equal $clog2(DATA_BUS_WIDTH).

Ports:
- clk_i  input  1  system clock; all logic on posedge.
- rst_n_i  input  1  asynchronous active-low reset.
- ser_data_i  input  1  serial data bit, MSB of the word first.
- ser_data_val_i  input  1  ser_data_i is valid this cycle.
- deser_data_o  output  DATA_BUS_WIDTH  reassembled word.
- deser_data_mod_o  output  DATA_MOD_WIDTH  number of valid bits in deser_data_o; 0 means all DATA_BUS_WIDTH bits.
- deser_data_val_o  output  1  one-cycle pulse: deser_data_o and deser_data_mod_o are valid.
- busy_o  input/none  n/a  not present; no backpressure exists, the sink must accept every pulse.

Behaviour:
- Reset: one clock, clk_i; asynchronous active-low reset rst_n_i.
  - While rst_n_i=0: state=IDLE_S, bit counter=0, shift buffer=0.
  - Outputs: deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0.
  - Assertion mid-burst discards the partial word; no pulse is generated for it.
- State machine, IDLE_S and RECV_S:
  - IDLE_S -> RECV_S when ser_data_val_i=1. That bit is captured as bit 1 of the word and the counter is set to 1.
  - RECV_S with ser_data_val_i=1: shift the bit in (buffer <= {buffer[W-2:0], ser_data_i}) and increment the counter.
  - RECV_S with ser_data_val_i=0: the burst is terminated; go to IDLE_S.
- Full word:
  - Complete when the DATA_BUS_WIDTH-th bit is sampled.
  - On that edge the output registers load. Next cycle: deser_data_val_o=1, deser_data_mod_o=0, deser_data_o=the word with the first received bit at bit W-1.
  - The counter returns to 0 and the state stays RECV_S.
  - If ser_data_val_i stays 1, the next bit starts a new word with no gap (back-to-back full words allowed).
  - If ser_data_val_i then drops with counter=0, go to IDLE_S with no pulse.
- Partial word:
  - Burst of k bits, 3 <= k < DATA_BUS_WIDTH, ended by ser_data_val_i=0.
  - On the edge sampling val=0 the output registers load.
  - Next cycle: deser_data_val_o=1, deser_data_mod_o=k, deser_data_o has the k bits left-aligned (first bit at W-1) and the lower W-k bits zero.
- Runt bursts: k=1 or k=2 are dropped silently. No pulse, outputs unchanged. This mirrors the serializer, which never sends 1- or 2-bit transactions.
- Output holding:
  - deser_data_val_o is a single-cycle pulse.
  - deser_data_o and deser_data_mod_o hold their last value until the next pulse.
- Latency: pulse appears 1 cycle after the edge that sampled the last bit (full word) or the first invalid cycle (partial word).
- Counter width: $clog2(DATA_BUS_WIDTH+1) bits. It never exceeds DATA_BUS_WIDTH; it wraps to 0 on word completion.
- ser_data_i is ignored (don't care) whenever ser_data_val_i=0.

Optional Feature:
- Macro: DESERIALIZER_LSB_ALIGN_EN.
- Defined: partial words are right-aligned. The k received bits occupy deser_data_o[k-1:0], first bit at k-1, upper bits zero. Full words and deser_data_mod_o are unchanged.
- Undefined: left-aligned behaviour exactly as specified above.

Test Plan:
- Full word: 16 consecutive valid bits of 0xA5C3, MSB first, then val=0 -> exactly one pulse, 1 cycle after the 16th bit, with data=0xA5C3 and mod=0. No second pulse on val drop.
- Partial word: 5 bits 1,0,1,1,0 then val=0 -> one pulse with data=0xB000 and mod=5. With DESERIALIZER_LSB_ALIGN_EN defined: data=0x0016, mod=5.
- Runt bursts: burst of 2 bits (1,1), gap, burst of 1 bit -> no pulse; outputs keep their previous values.
- Back-to-back: 32 continuous valid bits 0x1234 then 0xFEDC -> two pulses 16 cycles apart, data 0x1234 then 0xFEDC, mod=0 both.
- Reset mid-burst: drive 9 bits, assert rst_n_i asynchronously mid-cycle -> outputs 0 immediately. After release, send 4 bits 1,1,1,1 + gap -> pulse with data=0xF000 and mod=4; the pre-reset bits do not appear.
- Minimum partial: 3 bits 1,0,1 then val=0 -> pulse with data=0xA000 and mod=3.
